// File: rtl/string_counter.sv
// string_counter: run-length counter for 128-bit string words.
// It collapses runs of identical consecutive words into 160-bit records
// {word, count}. Each record is presented with a one-cycle write strobe.
// A run whose count would pass 32'hFFFF_FFFF is split into several records.
module string_counter (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] InString,
    input  logic         enable,
    output logic [159:0] Out,
    output logic         write
);

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] COUNT_ONE = 32'd1;

    // Full-width equality; the all-zero word is an ordinary value.
    function automatic logic words_equal(input logic [127:0] a,
                                         input logic [127:0] b);
        words_equal = (a == b);
    endfunction

    // Record packing: the string goes in the upper bits and the count in the lower bits.
    function automatic logic [159:0] make_record(input logic [127:0] str,
                                                 input logic [31:0]  cnt);
        make_record = {str, cnt};
    endfunction

    logic [127:0] cur_str_r;
    logic [31:0]  count_r;
    logic         valid_r;
    logic [159:0] out_r;
    logic         write_r;

    logic [127:0] cur_str_s;
    logic [31:0]  count_s;
    logic         valid_s;
    logic [159:0] out_s;
    logic         write_s;
    logic         match_s;

    assign match_s = words_equal(InString, cur_str_r);

    // Next-state decision for one sampled word: open, extend, split or close a run.
    always_comb begin
        cur_str_s = cur_str_r;
        count_s   = count_r;
        valid_s   = valid_r;
        out_s     = out_r;
        write_s   = 1'b0;
        if (enable) begin
            if (!valid_r) begin
                // The first word after reset only opens a run.
                cur_str_s = InString;
                count_s   = COUNT_ONE;
                valid_s   = 1'b1;
            end else if (match_s) begin
                if (count_r == COUNT_MAX) begin
                    // The counter is saturated. Emit the full chunk and continue the same string at 1.
                    out_s   = make_record(cur_str_r, COUNT_MAX);
                    write_s = 1'b1;
                    count_s = COUNT_ONE;
                end else begin
                    count_s = count_r + COUNT_ONE;
                end
            end else begin
                // The word changed. Close the current run and open a new one.
                out_s     = make_record(cur_str_r, count_r);
                write_s   = 1'b1;
                cur_str_s = InString;
                count_s   = COUNT_ONE;
            end
        end else begin
            // Disabled cycles neither count nor break the run.
            cur_str_s = cur_str_r;
            count_s   = count_r;
        end
    end

    // State and output registers. The asynchronous reset discards any open run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_str_r <= 128'h0;
            count_r   <= 32'h0;
            valid_r   <= 1'b0;
            out_r     <= 160'h0;
            write_r   <= 1'b0;
        end else begin
            cur_str_r <= cur_str_s;
            count_r   <= count_s;
            valid_r   <= valid_s;
            out_r     <= out_s;
            write_r   <= write_s;
        end
    end

    assign Out   = out_r;
    assign write = write_r;

endmodule

// File: tb/tb_string_counter.sv
// Directed self-checking bench for string_counter.
module tb_string_counter;

    logic         clk;
    logic         reset;
    logic [127:0] InString;
    logic         enable;
    logic [159:0] Out;
    logic         write;

    int pass_cnt;
    int total_cnt;

    localparam logic [127:0] S_A  = "AAABBBCCC";
    localparam logic [127:0] S_X  = "xxxxxxxxx";
    localparam logic [127:0] S_L  = "llllllllll";
    localparam logic [127:0] S_B  = "BBBB";
    localparam logic [127:0] S_AB = "AB";
    localparam logic [127:0] S_ZZ = "ZZ";
    localparam logic [127:0] S_CD = "CD";
    localparam logic [127:0] S_Q  = "QQQ";
    localparam logic [127:0] S_R  = "RRR";
    localparam logic [127:0] S_NZ = "NZ";
    localparam logic [127:0] S_SAT = "SATURATE";
    localparam logic [127:0] S_END = "END";

    string_counter dut (
        .clk      (clk),
        .reset    (reset),
        .InString (InString),
        .enable   (enable),
        .Out      (Out),
        .write    (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one word. Then step past the next rising edge so the registered outputs can be sampled.
    task automatic drive(input logic [127:0] word, input logic en);
        InString = word;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        enable   = 1'b0;
        InString = 128'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive({$urandom, $urandom, $urandom, $urandom}, 1'b1);
            total_cnt++;
            if (Out !== 160'h0 || write !== 1'b0) begin
                $display("FAIL reset_hold[%0d]: Out=%h write=%b, want Out=0 write=0", i, Out, write);
            end else begin
                pass_cnt++;
            end
        end
        reset = 1'b1;
        // Build an open run and an emitted record. Then assert reset between clock edges.
        drive(S_Q, 1'b1);
        drive(S_R, 1'b1);
        drive(S_Q, 1'b1);
        drive(S_Q, 1'b1);
        total_cnt++;
        if (Out !== {S_R, 32'd1} || write !== 1'b0) begin
            $display("FAIL reset_prerun: Out=%h write=%b, want Out=%h write=0", Out, write, {S_R, 32'd1});
        end else begin
            pass_cnt++;
        end
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (Out !== 160'h0 || write !== 1'b0) begin
            $display("FAIL reset_async: Out=%h write=%b, want Out=0 write=0", Out, write);
        end else begin
            pass_cnt++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        // The open QQQ run was discarded, so R only opens a new run.
        drive(S_R, 1'b1);
        total_cnt++;
        if (Out !== 160'h0 || write !== 1'b0) begin
            $display("FAIL reset_discard: Out=%h write=%b, want Out=0 write=0", Out, write);
        end else begin
            pass_cnt++;
        end
        drive(S_Q, 1'b1);
        total_cnt++;
        if (Out !== {S_R, 32'd1} || write !== 1'b1) begin
            $display("FAIL reset_first_rec: Out=%h write=%b, want Out=%h write=1", Out, write, {S_R, 32'd1});
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_basic_runs();
        logic [127:0] w [9];
        logic         e [9];
        logic         ew [9];
        logic [159:0] eo [9];
        w  = '{S_A, S_A, S_X, S_X, S_X, S_L, S_ZZ, S_ZZ, S_L};
        e  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        eo = '{160'h0, 160'h0, {S_A, 32'd2}, {S_A, 32'd2}, {S_A, 32'd2},
               {S_X, 32'd3}, {S_X, 32'd3}, {S_X, 32'd3}, {S_X, 32'd3}};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(w[i], e[i]);
            total_cnt++;
            if (write !== ew[i] || Out !== eo[i]) begin
                $display("FAIL basic[%0d]: Out=%h write=%b, want Out=%h write=%b", i, Out, write, eo[i], ew[i]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] w [5];
        logic         ew [5];
        logic [159:0] eo [5];
        w  = '{S_A, S_B, S_A, S_B, S_A};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eo = '{160'h0, {S_A, 32'd1}, {S_B, 32'd1}, {S_A, 32'd1}, {S_B, 32'd1}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(w[i], 1'b1);
            total_cnt++;
            if (write !== ew[i] || Out !== eo[i]) begin
                $display("FAIL alternate[%0d]: Out=%h write=%b, want Out=%h write=%b", i, Out, write, eo[i], ew[i]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        drive(S_AB, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(S_ZZ, 1'b0);
            total_cnt++;
            if (write !== 1'b0 || Out !== 160'h0) begin
                $display("FAIL gate_gap[%0d]: Out=%h write=%b, want Out=0 write=0", i, Out, write);
            end else begin
                pass_cnt++;
            end
        end
        drive(S_AB, 1'b1);
        total_cnt++;
        if (write !== 1'b0) begin
            $display("FAIL gate_resume: write=%b, want 0", write);
        end else begin
            pass_cnt++;
        end
        drive(S_CD, 1'b1);
        total_cnt++;
        if (write !== 1'b1 || Out !== {S_AB, 32'd2}) begin
            $display("FAIL gate_record: Out=%h write=%b, want Out=%h write=1", Out, write, {S_AB, 32'd2});
        end else begin
            pass_cnt++;
        end
        drive(S_CD, 1'b1);
        total_cnt++;
        if (write !== 1'b0 || Out !== {S_AB, 32'd2}) begin
            $display("FAIL gate_single: Out=%h write=%b, want Out=%h write=0", Out, write, {S_AB, 32'd2});
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(S_SAT, 1'b1);
        #2;
        force dut.count_r = 32'hFFFF_FFFE;
        #1;
        release dut.count_r;
        drive(S_SAT, 1'b1);
        total_cnt++;
        if (write !== 1'b0 || Out !== 160'h0) begin
            $display("FAIL sat_reach_max: Out=%h write=%b, want Out=0 write=0", Out, write);
        end else begin
            pass_cnt++;
        end
        drive(S_SAT, 1'b1);
        total_cnt++;
        if (write !== 1'b1 || Out !== {S_SAT, 32'hFFFF_FFFF}) begin
            $display("FAIL sat_split: Out=%h write=%b, want Out=%h write=1", Out, write, {S_SAT, 32'hFFFF_FFFF});
        end else begin
            pass_cnt++;
        end
        drive(S_SAT, 1'b1);
        total_cnt++;
        if (write !== 1'b0) begin
            $display("FAIL sat_after: write=%b, want 0", write);
        end else begin
            pass_cnt++;
        end
        drive(S_END, 1'b1);
        total_cnt++;
        if (write !== 1'b1 || Out !== {S_SAT, 32'd2}) begin
            $display("FAIL sat_restart: Out=%h write=%b, want Out=%h write=1", Out, write, {S_SAT, 32'd2});
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_zero_word();
        do_reset();
        drive(128'h0, 1'b1);
        total_cnt++;
        if (write !== 1'b0) begin
            $display("FAIL zero_open: write=%b, want 0", write);
        end else begin
            pass_cnt++;
        end
        drive(S_NZ, 1'b1);
        total_cnt++;
        if (write !== 1'b1 || Out !== {128'h0, 32'd1}) begin
            $display("FAIL zero_record: Out=%h write=%b, want Out=%h write=1", Out, write, {128'h0, 32'd1});
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        enable    = 1'b0;
        InString  = 128'h0;
        test_reset();
        test_basic_runs();
        test_back_to_back();
        test_enable_gating();
        test_saturation();
        test_zero_word();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/string_counter.md
# string_counter

Run-length counter for 128-bit string words in the genome-compression datapath. Each enabled cycle it samples one input word and compares it with the word currently being counted. Identical consecutive words extend the run. A different word closes the run and emits a 160-bit record of the word and its repeat count, with a one-cycle write strobe that feeds the downstream record writer/FIFO.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- InString  input  128  string word, 16 ASCII bytes; shorter strings are right-justified with zero-padded upper bytes.
- enable  input  1  when 1, InString is sampled on this clock edge.
- Out  output  160  emitted record: Out[159:32] = run string, Out[31:0] = run count (unsigned).
- write  output  1  one-cycle strobe; Out holds a new valid record while write = 1.

## Operation
- Internal state:
  - cur_str[127:0]: string being counted.
  - count[31:0]: length of the current run.
  - valid: 1 once a run has started.
- Reset asserted (reset = 0), applied immediately and independent of clk:
  - cur_str = 0, count = 0, valid = 0.
  - Out = 0, write = 0.
  - An open run is discarded and no record is emitted. This also applies when reset is asserted mid-run.
- On each rising clk with reset = 1 and enable = 1:
  - If valid = 0: cur_str ← InString, count ← 1, valid ← 1, write ← 0.
  - If valid = 1 and InString == cur_str, with count < 32'hFFFF_FFFF: count ← count + 1, write ← 0.
  - If valid = 1 and InString == cur_str, with count = 32'hFFFF_FFFF (saturation):
    - Out ← {cur_str, 32'hFFFF_FFFF}, write ← 1, count ← 1.
    - The run is split and cur_str is unchanged.
  - If valid = 1 and InString != cur_str:
    - Out ← {cur_str, count}, write ← 1.
    - cur_str ← InString, count ← 1.
- On each rising clk with reset = 1 and enable = 0:
  - All state and Out hold.
  - write ← 0.
- Comparison is a full 128-bit equality. The all-zero word is a legal string value.
- Out is never cleared except by reset. It holds the last emitted record until the next emission.
- There is no flush input. The final open run is emitted only when a different word arrives on a later enabled cycle.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the record for a run appears on Out, with write = 1, in the cycle immediately after the clock edge that sampled the first differing word.
- write is high for exactly one cycle per record.
- Back-to-back records are possible when the word changes on every enabled cycle. In that case write stays high on consecutive cycles, and Out updates each cycle with count = 1.
- A gap in enable does not break a run: disabled cycles are ignored and do not count.
- Reset release: the first enabled edge after reset deasserts only opens a run. The earliest write is on the second enabled edge.

## Test plan
- **Reset:** hold reset = 0 with arbitrary InString and enable = 1 -> Out = 0 and write = 0 throughout. Assert reset asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- **Basic runs:** release reset, then enabled words in order: "AAABBBCCC" ×2, "xxxxxxxxx" ×3, "llllllllll".
  - One cycle after the first "x" is sampled: write = 1 with Out = {"AAABBBCCC" zero-padded, 32'd2}.
  - One cycle after "l" is sampled: write = 1 with Out = {"xxxxxxxxx" zero-padded, 32'd3}.
  - write = 0 on every other cycle.
- **Alternating words:** alternate words A, B, A, B every cycle -> write held at 1 from the second sample onward, Out = {prev, 1} each cycle.
- **Enable gating:** "AB" enabled, then enable = 0 for 5 cycles with InString = "ZZ", then "AB" enabled, then "CD" enabled -> single record {"AB", 2}. The "ZZ" cycles are ignored and write = 0 during the gap.
- **Saturation:** force count to 32'hFFFF_FFFE, then feed 2 more matching words -> count reaches FFFF_FFFF without a write; the next match emits {str, FFFF_FFFF} and count restarts at 1.
- **Zero word:** feed InString = 0 as the first word after reset, then a nonzero word -> record {128'h0, 1} is emitted. The zero word is treated as a legal string.
